baud_rate_ctrl: RTL and testbench

Configuration controller for the serial link's programmable clock divider. It holds the active divide rate and accepts rate-change requests over a valid/ready handshake. It validates each request, defers it until the serial datapath reports idle, then applies it with a divider resync pulse. It reports lock once the divider output is seen running at the new rate.

---
 rtl/baud_rate_ctrl.sv | 145 ++++++++++++++
 tb/tb_baud_rate_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_ctrl.sv
// Rate-change controller for the serial link clock divider.
// Accepts a new divide rate over valid/ready, validates it, waits for the
// datapath to go idle, resyncs the divider and reports lock on its first rise.
module baud_rate_ctrl #(
  parameter logic [13:0] DEFAULT_RATE  = 14'd5208,
  parameter logic [13:0] MIN_RATE      = 14'd4,
  parameter int unsigned RESYNC_CYCLES = 2,
  parameter int unsigned LOCK_TIMEOUT  = 8
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [13:0] req_rate,
  output logic        req_ready,
  input  logic        link_busy,
  output logic [13:0] div_rate,
  output logic        div_reset_n,
  input  logic        div_clk_out,
  output logic        locked,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_IDLE,
    APPLY,
    LOCK
  } state_t;

  localparam logic [7:0] RESYNC_LAST = 8'(RESYNC_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_TIMEOUT - 1);

  state_t      state, state_next;
  logic [13:0] pending;
  logic [7:0]  cnt;
  logic        clk_prev;
  // High from reset until the boot-time lock attempt finishes; it forces the
  // first APPLY and suppresses the done pulse for that sequence.
  logic        boot;

  logic accept, start_apply, release_div, lock_ok, lock_fail, chk_err, chk_done;

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and one-cycle control strobes
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    accept      = 1'b0;
    start_apply = 1'b0;
    release_div = 1'b0;
    lock_ok     = 1'b0;
    lock_fail   = 1'b0;
    chk_err     = 1'b0;
    chk_done    = 1'b0;
    case (state)
      IDLE: begin
        if (boot) begin
          start_apply = 1'b1;
          state_next  = APPLY;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept     = 1'b1;
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (pending[0] || (pending < MIN_RATE)) begin
          chk_err    = 1'b1;
          state_next = IDLE;
        end else if ((pending == div_rate) && locked) begin
          chk_done   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!link_busy) begin
          start_apply = 1'b1;
          state_next  = APPLY;
        end
      end
      APPLY: begin
        if (cnt == RESYNC_LAST) begin
          release_div = 1'b1;
          state_next  = LOCK;
        end
      end
      LOCK: begin
        if (div_clk_out && !clk_prev) begin
          lock_ok    = 1'b1;
          state_next = IDLE;
        end else if (cnt == LOCK_LAST) begin
          lock_fail  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Rate registers, divider control, lock status and result pulses
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pending     <= DEFAULT_RATE;
      div_rate    <= DEFAULT_RATE;
      div_reset_n <= 1'b0;
      locked      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      boot        <= 1'b1;
      cnt         <= '0;
      clk_prev    <= 1'b0;
    end else begin
      clk_prev <= div_clk_out;
      done     <= chk_done | (lock_ok & ~boot);
      err      <= chk_err | lock_fail;
      if (accept) pending <= req_rate;
      // cnt is shared: resync length in APPLY, then cycles since release in LOCK
      if (start_apply) begin
        div_rate    <= pending;
        locked      <= 1'b0;
        div_reset_n <= 1'b0;
        cnt         <= '0;
      end else if (release_div) begin
        div_reset_n <= 1'b1;
        cnt         <= '0;
      end else if ((state == APPLY) || (state == LOCK)) begin
        cnt <= cnt + 8'd1;
      end
      if (lock_ok) locked <= 1'b1;
      if (lock_ok || lock_fail) boot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Self-checking bench for baud_rate_ctrl with a behavioural divider model.
module tb_baud_rate_ctrl;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [13:0] req_rate = '0;
  logic        req_ready;
  logic        link_busy = 1'b0;
  logic [13:0] div_rate;
  logic        div_reset_n;
  logic        div_clk_out;
  logic        locked, done, err;

  baud_rate_ctrl #(
    .DEFAULT_RATE (14'd5208),
    .MIN_RATE     (14'd4),
    .RESYNC_CYCLES(2),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rate   (req_rate),
    .req_ready  (req_ready),
    .link_busy  (link_busy),
    .div_rate   (div_rate),
    .div_reset_n(div_reset_n),
    .div_clk_out(div_clk_out),
    .locked     (locked),
    .done       (done),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  // Divider model: output high for the first half of each div_rate period
  logic [13:0] dcnt;
  logic        dout;
  logic        force_low = 1'b0;
  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      dcnt <= '0;
      dout <= 1'b0;
    end else if (!div_reset_n) begin
      dcnt <= '0;
      dout <= 1'b0;
    end else begin
      dcnt <= (dcnt == div_rate - 14'd1) ? 14'd0 : dcnt + 14'd1;
      dout <= (dcnt < (div_rate >> 1));
    end
  end
  assign div_clk_out = dout & ~force_low;

  // Observers: resync cycles and result pulses seen while out of reset
  int low_count = 0;
  int pulse_total = 0;
  always @(negedge clk_in) begin
    if (reset && !div_reset_n) low_count++;
    if (reset && (done || err)) pulse_total++;
  end

  typedef struct {
    logic        d;
    logic        e;
    logic [13:0] rate;
    logic        lk;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [13:0] rate;
    logic        exp_done;
    logic        exp_err;
    logic [13:0] exp_rate;
    logic        exp_locked;
    int          exp_lows;
  } vec_t;
  vec_t vecs[7];

  int compared = 0;
  int mismatched = 0;
  int pulses_scored = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score();
    sb_t e;
    pulses_scored++;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL outcome: got pulse done=%0b err=%0b expected none", done, err);
    end else begin
      e = sb.pop_front();
      chk("outcome{done,err,locked,rate}", {done, err, locked, div_rate},
          {e.d, e.e, e.lk, e.rate});
    end
  endtask

  task automatic wait_pulse(input int bound);
    logic got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (done || err) begin
        got = 1'b1;
        break;
      end
    end
    chk("pulse_wait", got, 1);
    if (got) score();
  endtask

  task automatic wait_lock(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (locked) break;
    end
    chk(name, locked, 1);
  endtask

  task automatic send(input logic [13:0] rate, input logic ed, input logic ee,
                      input logic [13:0] er, input logic el);
    sb_t e;
    e.d = ed; e.e = ee; e.rate = er; e.lk = el;
    sb.push_back(e);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (req_ready) break;
    end
    chk("ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_rate  = rate;
    @(negedge clk_in);
    req_valid = 1'b0;
    chk("ready_drop", req_ready, 0);
  endtask

  task automatic measure_period(output int p);
    logic last;
    int   t_first;
    p = 0;
    t_first = -1;
    last = div_clk_out;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (div_clk_out && !last) begin
        if (t_first < 0) t_first = i;
        else begin
          p = i - t_first;
          break;
        end
      end
      last = div_clk_out;
    end
  endtask

  initial begin
    int base, per, bad, k;

    vecs[0] = '{14'd433,  1'b0, 1'b1, 14'd434, 1'b1, 0};
    vecs[1] = '{14'd2,    1'b0, 1'b1, 14'd434, 1'b1, 0};
    vecs[2] = '{14'd3,    1'b0, 1'b1, 14'd434, 1'b1, 0};
    vecs[3] = '{14'd434,  1'b1, 1'b0, 14'd434, 1'b1, 0};
    vecs[4] = '{14'd4,    1'b1, 1'b0, 14'd4,   1'b1, 2};
    vecs[5] = '{14'd5,    1'b0, 1'b1, 14'd4,   1'b1, 0};
    vecs[6] = '{14'd434,  1'b1, 1'b0, 14'd434, 1'b1, 2};

    // Reset values, then the boot resync/lock sequence
    #12;
    chk("reset_outputs", {div_rate, div_reset_n, req_ready, locked, done, err},
        {14'd5208, 5'b0});
    @(negedge clk_in);
    #2 reset = 1'b1;
    base = low_count;
    wait_lock("boot_lock", 12);
    chk("boot_resync_cycles", low_count - base, 2);
    chk("boot_rate", div_rate, 5208);
    chk("boot_no_pulse", pulse_total, 0);

    // First real request
    base = low_count;
    send(14'd434, 1'b1, 1'b0, 14'd434, 1'b1);
    wait_pulse(100);
    chk("req434_resync_cycles", low_count - base, 2);
    measure_period(per);
    chk("period_434", per, 434);

    // Table: rejects, same-rate shortcut, MIN_RATE boundary
    foreach (vecs[i]) begin
      base = low_count;
      send(vecs[i].rate, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_rate, vecs[i].exp_locked);
      wait_pulse(100);
      chk($sformatf("vec%0d_resync_cycles", i), low_count - base, vecs[i].exp_lows);
    end

    // Lock timeout: err exactly 8 cycles after release, then a clean retry
    force_low = 1'b1;
    send(14'd868, 1'b0, 1'b1, 14'd868, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (!div_reset_n) break;
    end
    for (int i = 0; i < 50; i++) begin
      if (div_reset_n) break;
      @(negedge clk_in);
    end
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      k++;
      if (done || err) break;
    end
    chk("timeout_delay", k, 8);
    score();
    @(negedge clk_in);
    chk("timeout_state{div_reset_n,locked}", {div_reset_n, locked}, 2'b10);
    force_low = 1'b0;
    base = low_count;
    send(14'd868, 1'b1, 1'b0, 14'd868, 1'b1);
    wait_pulse(100);
    chk("retry_resync_cycles", low_count - base, 2);

    // Busy datapath defers the apply
    link_busy = 1'b1;
    send(14'd434, 1'b1, 1'b0, 14'd434, 1'b1);
    bad = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (div_rate != 14'd868 || !locked || !div_reset_n || done || err) bad++;
    end
    chk("busy_hold", bad, 0);
    link_busy = 1'b0;
    @(negedge clk_in);
    chk("apply_after_busy{div_reset_n,rate}", {div_reset_n, div_rate}, {1'b0, 14'd434});
    wait_pulse(100);

    // Reset during APPLY aborts immediately
    send(14'd868, 1'b1, 1'b0, 14'd868, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (!div_reset_n) break;
    end
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {div_rate, div_reset_n, req_ready, locked, done, err},
        {14'd5208, 5'b0});
    sb.delete();
    @(negedge clk_in);
    #2 reset = 1'b1;
    wait_lock("reboot_lock", 12);
    chk("reboot_rate", div_rate, 5208);
    base = low_count;
    send(14'd5208, 1'b1, 1'b0, 14'd5208, 1'b1);
    wait_pulse(10);
    chk("same_rate_no_resync", low_count - base, 0);

    repeat (5) @(negedge clk_in);
    chk("pulse_count", pulse_total, pulses_scored);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
